// File: rtl/gate_sweep_checker.sv
// Self-test driver/checker for the two-input gate block: sweeps {a,b} through
// 00..11, waits SETTLE_CYCLES per vector, and compares gate_vec against a golden table.
module gate_sweep_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic [6:0]       gate_vec,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [6:0]       fail_mask,
  output logic [1:0]       first_fail_ab,
  output logic             first_fail_valid
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t          state;
  logic [1:0]      idx;
  logic [CW-1:0]   cnt;
  logic [6:0]      golden;
  logic [6:0]      mismatch;
  logic [ERR_W-1:0] err_next;

  always_comb begin
    golden   = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    mismatch = gate_vec ^ golden;
    err_next = err_count;
    if (mismatch != '0 && err_count != '1)
      err_next = err_count + ERR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      a                <= 1'b0;
      b                <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      fail_mask        <= '0;
      first_fail_ab    <= '0;
      first_fail_valid <= 1'b0;
      idx              <= '0;
      cnt              <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            err_count        <= '0;
            fail_mask        <= '0;
            first_fail_ab    <= '0;
            first_fail_valid <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            a                <= 1'b0;
            b                <= 1'b0;
            idx              <= '0;
            cnt              <= CW'(SETTLE_CYCLES - 1);
            busy             <= 1'b1;
            state            <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) state <= SAMPLE;
          else           cnt   <= cnt - 1'b1;
        end
        SAMPLE: begin
          err_count <= err_next;
          if (mismatch != '0) begin
            fail_mask <= fail_mask | mismatch;
            if (!first_fail_valid) begin
              first_fail_ab    <= {a, b};
              first_fail_valid <= 1'b1;
            end
          end
          if (idx != 2'd3) begin
            idx   <= idx + 2'd1;
            {a, b} <= idx + 2'd1;
            cnt   <= CW'(SETTLE_CYCLES - 1);
            state <= SETTLE;
          end else begin
            // err_next already includes this cycle's mismatch
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: fault-injecting gate model plus an edge-count
// based reference model, run on an ERR_W=8 and an ERR_W=2 instance in parallel.
module tb_gate_sweep_checker;

  localparam int S = 2;
  localparam int P = S + 1;
  localparam logic [3:0] TT [7] = '{4'b1000, 4'b1110, 4'b0011, 4'b0111,
                                    4'b0001, 4'b0110, 4'b1001};

  logic clk = 1'b0;
  logic rst, start;
  logic [6:0] flip [4];

  logic a8, b8, busy8, done8, pass8, fv8;
  logic [7:0] err8;
  logic [6:0] mask8, gv8;
  logic [1:0] ff8;
  logic a2, b2, busy2, done2, pass2, fv2;
  logic [1:0] err2;
  logic [6:0] mask2, gv2;
  logic [1:0] ff2;

  int tests = 0;
  int fails = 0;

  int   t = 0;
  bit   started = 0;
  int   m_err = 0;
  logic [6:0] m_mask = '0;
  logic [1:0] m_first = '0;
  bit   m_fv = 0;

  always #5 clk = ~clk;

  function automatic logic [6:0] golden(input logic [1:0] v);
    logic [6:0] r;
    logic [3:0] row;
    for (int g = 0; g < 7; g++) begin
      row  = TT[g];
      r[g] = row[v];
    end
    return r;
  endfunction

  assign gv8 = golden({a8, b8}) ^ flip[{a8, b8}];
  assign gv2 = golden({a2, b2}) ^ flip[{a2, b2}];

  gate_sweep_checker #(.SETTLE_CYCLES(S), .ERR_W(8)) u8 (
    .clk(clk), .rst(rst), .start(start), .a(a8), .b(b8), .gate_vec(gv8),
    .busy(busy8), .done(done8), .pass(pass8), .err_count(err8),
    .fail_mask(mask8), .first_fail_ab(ff8), .first_fail_valid(fv8));

  gate_sweep_checker #(.SETTLE_CYCLES(S), .ERR_W(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .a(a2), .b(b2), .gate_vec(gv2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_mask(mask2), .first_fail_ab(ff2), .first_fail_valid(fv2));

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on each edge; t counts edges since the accepting edge.
  task automatic model_step();
    int k;
    if (rst) begin
      started = 0; t = 0; m_err = 0; m_mask = '0; m_first = '0; m_fv = 0;
    end else if (start && (!started || t >= 4 * P)) begin
      started = 1; t = 0; m_err = 0; m_mask = '0; m_first = '0; m_fv = 0;
    end else if (started && t < 4 * P) begin
      t++;
      if (t % P == 0) begin
        k = t / P - 1;
        if (flip[k] != '0) begin
          m_err++;
          m_mask |= flip[k];
          if (!m_fv) begin m_first = 2'(k); m_fv = 1; end
        end
      end
    end
  endtask

  always @(posedge clk) begin
    int q, eidx, e8, e2;
    bit ebusy, edone, epass;
    model_step();
    #1;
    q     = t / P;
    eidx  = started ? (q > 3 ? 3 : q) : 0;
    ebusy = started && t < 4 * P;
    edone = started && t >= 4 * P;
    epass = edone && m_err == 0;
    e8    = m_err > 255 ? 255 : m_err;
    e2    = m_err > 3 ? 3 : m_err;
    chk("ab8",    {a8, b8}, eidx);
    chk("busy8",  busy8, ebusy);
    chk("done8",  done8, edone);
    chk("pass8",  pass8, epass);
    chk("err8",   err8, e8);
    chk("mask8",  mask8, m_mask);
    chk("first8", {fv8, ff8}, {m_fv, m_first});
    chk("ab2",    {a2, b2}, eidx);
    chk("done2",  {busy2, done2, pass2}, {ebusy, edone, epass});
    chk("err2",   err2, e2);
    chk("mask2",  {fv2, ff2, mask2}, {m_fv, m_first, m_mask});
  end

  task automatic set_flip(input logic [6:0] f0, f1, f2, f3);
    flip[0] = f0; flip[1] = f1; flip[2] = f2; flip[3] = f3;
  endtask

  // Pulses start, optionally re-pulses it after restart_at edges, returns edges to done.
  task automatic run_sweep(input int restart_at, output int lat);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk) start = (lat == restart_at);
      @(posedge clk);
      #1 lat++;
      if (done8) break;
    end
    @(negedge clk) start = 1'b0;
    if (lat >= 200) chk("timeout", lat, 12);
  endtask

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0;
    set_flip('0, '0, '0, '0);
    #1;
    chk("rst_outs", {a8, b8, busy8, done8, pass8, fv8, ff8}, 0);
    chk("rst_err", {err8, mask8}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: clean sweep
    run_sweep(-1, lat);
    chk("lat_clean", lat, 12);
    chk("pass_clean", {pass8, err8, mask8, fv8}, {1'b1, 8'd0, 7'd0, 1'b0});

    // 2: AND stuck-at-0, only vector 11 differs
    set_flip('0, '0, '0, 7'h01);
    run_sweep(-1, lat);
    chk("err_and", err8, 1);
    chk("mask_and", mask8, 7'h01);
    chk("first_and", {fv8, ff8}, 3'b111);
    chk("pass_and", pass8, 0);

    // 6: restart from DONE with a good model
    set_flip('0, '0, '0, '0);
    run_sweep(-1, lat);
    chk("clear_res", {pass8, err8, mask8}, {1'b1, 8'd0, 7'd0});

    // 3: xor/xnor swapped; narrow counter saturates
    set_flip(7'h60, 7'h60, 7'h60, 7'h60);
    run_sweep(-1, lat);
    chk("err_xor", err8, 4);
    chk("err_xor_sat", err2, 3);
    chk("mask_xor", mask8, 7'h60);
    chk("first_xor", {fv8, ff8}, 3'b100);

    // 4: start during SETTLE of vector 01 is ignored
    set_flip('0, '0, '0, '0);
    run_sweep(3, lat);
    chk("lat_restart", lat, 12);
    chk("pass_restart", pass8, 1);

    // 5: async reset while vector 10 is held
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk("ab_before_rst", {a8, b8}, 2'b10);
    #1 rst = 1'b1;
    #1;
    chk("async_outs", {a8, b8, busy8, done8, pass8, fv8, ff8}, 0);
    chk("async_err", {err8, mask8, err2}, 0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    run_sweep(-1, lat);
    chk("lat_post_rst", lat, 12);
    chk("pass_post_rst", pass8, 1);

    // random fault tables and random ignored restarts
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 4; k++)
        flip[k] = ($urandom_range(0, 1) != 0) ? 7'($urandom) : 7'd0;
      run_sweep(int'($urandom_range(0, 10)), lat);
      chk("lat_rand", lat, 12);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
Sequential stimulus-and-check stage wrapped around the two-input logic-gate block. It drives the gate block's a/b inputs through all four input combinations and waits a programmable settle time after each one. It then samples the seven gate outputs, compares them against an internally computed golden truth table, and reports error count, per-gate failure mask, first failing vector and pass/fail. It acts as the gate block's upstream driver and downstream consumer in on-chip self-test.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range >= 1.
ERR_W, 8, width of err_count; the counter saturates at 2^ERR_W-1.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous active-high reset.
start  input  1  starts a sweep; sampled only in IDLE or DONE.
a  output  1  gate input A, registered.
b  output  1  gate input B, registered.
gate_vec  input  7  gate outputs; bit0 and, bit1 or, bit2 not(A), bit3 nand, bit4 nor, bit5 xor, bit6 xnor.
busy  output  1  high from the cycle after start is accepted until DONE.
done  output  1  level, high in DONE until the next accepted start or reset.
pass  output  1  high in DONE when err_count==0; low otherwise.
err_count  output  ERR_W  number of vectors with any mismatch, saturating.
fail_mask  output  7  sticky OR of per-gate mismatches across the sweep.
first_fail_ab  output  2  {a,b} of the first failing vector.
first_fail_valid  output  1  first_fail_ab holds a captured vector.

Behaviour:
- Reset (async, any state): state=IDLE; a=b=0; busy=done=pass=0; err_count=0; fail_mask=0; first_fail_ab=0; first_fail_valid=0; vector index=0; settle counter=0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- Accepting start (state IDLE or DONE, start=1 at edge):
  - clear err_count, fail_mask, first_fail_*, done and pass;
  - set {a,b}=00, index=0, settle counter=SETTLE_CYCLES-1, busy=1;
  - go to SETTLE.
- start while in SETTLE or SAMPLE: ignored; no restart and no effect on results.
- SETTLE: decrement the counter each cycle. When the counter==0, go to SAMPLE. SETTLE lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle): mismatch = gate_vec XOR golden(a,b).
  - golden bit order: bit0 a&b, bit1 a|b, bit2 ~a, bit3 ~(a&b), bit4 ~(a|b), bit5 a^b, bit6 ~(a^b).
  - If mismatch is nonzero:
    - err_count += 1, saturating at all-ones;
    - fail_mask |= mismatch;
    - if first_fail_valid==0, capture first_fail_ab={a,b} and set first_fail_valid=1.
  - If index<3: index+1; drive the next vector in sequence 00, 01, 10, 11 ({a,b} = index, a is the MSB); reload the counter to SETTLE_CYCLES-1; go to SETTLE.
  - If index==3: go to DONE; busy=0; done=1; pass = (final err_count==0), including this cycle's update.
- DONE: hold all results. a and b hold 11 until the next start.
- Latency: done rises at the 4*(SETTLE_CYCLES+1)-th rising edge after the edge that accepts start.
- All outputs are registered; there are no combinational paths from gate_vec to any output.
- Reset asserted mid-sweep: outputs return to reset values immediately, without waiting for a clock edge. After release the block waits in IDLE for start.

Test Plan:
1. Correct gate model, SETTLE_CYCLES=2, pulse start -> a/b sequence 00,01,10,11, each held 3 cycles; done at edge 12; pass=1; err_count=0; fail_mask=0; first_fail_valid=0.
2. AND output stuck-at-0 -> only vector 11 fails; err_count=1; fail_mask=7'b0000001; first_fail_ab=2'b11; pass=0.
3. xor/xnor bits swapped -> all 4 vectors fail; err_count=4; fail_mask=7'b1100000; first_fail_ab=2'b00. Repeat with ERR_W=2 -> err_count=3 (saturated).
4. Pulse start again during SETTLE of vector 1 -> ignored; sweep completes at the original edge-12 timing with unchanged results.
5. Assert rst asynchronously while vector 10 is held -> all outputs 0 immediately, state IDLE. New start after release -> full clean sweep with pass=1.
6. Start from DONE after a failing run (scenario 2), now with a correct gate model -> results cleared on acceptance; final err_count=0; pass=1; fail_mask=0.
